// File: rtl/sta_result_drain_if.sv
// Result stream from the tensor-array drain to requant/writeback.
// Master drives beats; slave returns ready.
interface sta_result_drain_if #(
  parameter int N     = 4,
  parameter int ACC_W = 32
);
  localparam int RW = $clog2(N);

  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic [RW-1:0]           out_row;
  logic [RW-1:0]           out_col;
  logic                    out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_col,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/sta_result_drain.sv
// Snapshot the NxN accumulators on capture and stream the
// active entries in row-major order, one beat per handshake.
module sta_result_drain #(
  parameter int N     = 4,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture,
  input  logic [N*ACC_W-1:0]   c0_in,
  input  logic [N*ACC_W-1:0]   c1_in,
  input  logic [N*ACC_W-1:0]   c2_in,
  input  logic [N*ACC_W-1:0]   c3_in,
  input  logic [N*N-1:0]       pe_mask,
  sta_result_drain_if.master   out,
  output logic                 busy,
  output logic                 array_released,
  output logic                 drain_done,
  output logic                 capture_overrun
);

  localparam int E  = N * N;
  localparam int IW = $clog2(E);
  localparam int RW = $clog2(N);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] shadow_q [E];
  logic [E-1:0]     mask_q;
  logic [IW-1:0]    idx_q;
  logic             rel_q;
  logic             done_q;
  logic             ovr_q;

  logic [N*ACC_W-1:0] rows_w [N];
  logic [IW-1:0]      first_d;
  logic [IW-1:0]      next_d;
  logic               last_d;
  logic               hs;

  assign rows_w[0] = c0_in;
  assign rows_w[1] = c1_in;
  assign rows_w[2] = c2_in;
  assign rows_w[3] = c3_in;

  // Lowest set bit of the incoming mask: first entry to emit.
  always_comb begin
    first_d = '0;
    for (int i = E - 1; i >= 0; i--) begin
      if (pe_mask[i]) first_d = IW'(i);
    end
  end

  // Next active entry above idx; none found means this beat is last.
  always_comb begin
    next_d = idx_q;
    last_d = 1'b1;
    for (int i = E - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(idx_q))) begin
        next_d = IW'(i);
        last_d = 1'b0;
      end
    end
  end

  assign hs = (state_q == DRAIN) && out.out_ready;

  // Drain FSM with snapshot capture and registered status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      rel_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < E; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      rel_q  <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (capture) begin
            rel_q <= 1'b1;
            if (|pe_mask) begin
              for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                  shadow_q[r*N+c] <= rows_w[r][c*ACC_W +: ACC_W];
                end
              end
              mask_q  <= pe_mask;
              idx_q   <= first_d;
              state_q <= DRAIN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          ovr_q <= capture;
          if (hs) begin
            if (last_d) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              idx_q <= next_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out.out_valid   = (state_q == DRAIN);
  assign out.out_data    = shadow_q[idx_q];
  assign out.out_row     = idx_q[IW-1:RW];
  assign out.out_col     = idx_q[RW-1:0];
  assign out.out_last    = (state_q == DRAIN) && last_d;
  assign busy            = (state_q == DRAIN);
  assign array_released  = rel_q;
  assign drain_done      = done_q;
  assign capture_overrun = ovr_q;

endmodule

// File: tb/tb_sta_result_drain.sv
// Scoreboard bench for sta_result_drain: stimulus pushes expected
// beats and pulses, a negedge monitor pops and compares.
module tb_sta_result_drain;

  localparam int N     = 4;
  localparam int ACC_W = 32;
  localparam int E     = N * N;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               capture = 1'b0;
  logic [N*ACC_W-1:0] c_in [N];
  logic [E-1:0]       pe_mask = '0;
  logic               busy;
  logic               array_released;
  logic               drain_done;
  logic               capture_overrun;

  sta_result_drain_if #(.N(N), .ACC_W(ACC_W)) bus ();

  sta_result_drain #(.N(N), .ACC_W(ACC_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .capture         (capture),
    .c0_in           (c_in[0]),
    .c1_in           (c_in[1]),
    .c2_in           (c_in[2]),
    .c3_in           (c_in[3]),
    .pe_mask         (pe_mask),
    .out             (bus.master),
    .busy            (busy),
    .array_released  (array_released),
    .drain_done      (drain_done),
    .capture_overrun (capture_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int row;
    int col;
    bit last;
  } beat_t;

  beat_t sb [$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    ready_mode = 0;
  int    cv [E];

  bit mon_en = 0;
  bit act = 0;
  bit pend_start = 0;
  bit pend_rel = 0;
  bit pend_done = 0;
  bit pend_ovr = 0;
  bit cur_rel = 0;
  bit cur_done = 0;
  bit cur_ovr = 0;
  bit held = 0;
  beat_t held_b;

  task automatic chk(string name, logic signed [63:0] got,
                     logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
  always @(posedge clk) begin
    #1;
    cyc++;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: per-cycle status checks and scoreboard pops.
  always @(negedge clk) begin
    if (mon_en) begin
      bit clr;
      beat_t b;
      clr = 0;
      chk("valid", bus.out_valid, act);
      chk("busy", busy, act);
      chk("released", array_released, cur_rel);
      chk("done", drain_done, cur_done);
      chk("overrun", capture_overrun, cur_ovr);
      if (held && bus.out_valid) begin
        chk("stall_data", bus.out_data, held_b.data);
        chk("stall_row", bus.out_row, held_b.row);
        chk("stall_col", bus.out_col, held_b.col);
        chk("stall_last", bus.out_last, held_b.last);
      end
      held = 0;
      if (!reset && bus.out_valid) begin
        if (bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_beat got=%0d exp=none", bus.out_data);
          end else begin
            b = sb.pop_front();
            chk("data", bus.out_data, b.data);
            chk("row", bus.out_row, b.row);
            chk("col", bus.out_col, b.col);
            chk("last", bus.out_last, b.last);
            if (b.last) begin
              clr = 1;
              pend_done = 1;
            end
          end
        end else begin
          held = 1;
          held_b.data = bus.out_data;
          held_b.row  = int'(bus.out_row);
          held_b.col  = int'(bus.out_col);
          held_b.last = bus.out_last;
        end
      end
      if (reset) begin
        sb.delete();
        act = 0;
        pend_start = 0;
        pend_rel = 0;
        pend_done = 0;
        pend_ovr = 0;
        cur_rel = 0;
        cur_done = 0;
        cur_ovr = 0;
      end else begin
        cur_rel  = pend_rel;
        cur_done = pend_done;
        cur_ovr  = pend_ovr;
        pend_rel = 0;
        pend_done = 0;
        pend_ovr = 0;
        if (clr) act = 0;
        if (pend_start) act = 1;
        pend_start = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scribble();
    for (int r = 0; r < N; r++) begin
      c_in[r] = {$urandom, $urandom, $urandom, $urandom};
    end
    pe_mask = E'($urandom);
  endtask

  // Drive one capture of cv[] with mask m and record expectations.
  task automatic do_cap(logic [E-1:0] m);
    int last_i;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        c_in[r][c*ACC_W +: ACC_W] = cv[r*N+c];
      end
    end
    pe_mask = m;
    capture = 1'b1;
    if (act || pend_start) begin
      pend_ovr = 1;
    end else begin
      pend_rel = 1;
      if (m == '0) begin
        pend_done = 1;
      end else begin
        pend_start = 1;
        last_i = -1;
        for (int i = 0; i < E; i++) if (m[i]) last_i = i;
        for (int i = 0; i < E; i++) begin
          if (m[i]) sb.push_back('{cv[i], i / N, i % N, i == last_i});
        end
      end
    end
    tick();
    capture = 1'b0;
    scribble();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((act || pend_start) && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (act || pend_start) begin
      failures++;
      $display("FAIL drain_timeout got=busy exp=idle");
    end
    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic wait_left(int left);
    int n;
    n = 0;
    while (sb.size() > left && n < 500) begin
      tick();
      n++;
    end
    chk("wait_left", (sb.size() <= left), 1);
  endtask

  task automatic load_grid();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        cv[r*N+c] = r * 100 + c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_ready = 1'b0;
    for (int r = 0; r < N; r++) c_in[r] = '0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    mon_en = 1;
    repeat (2) tick();

    // Full mask, ready high.
    ready_mode = 0;
    load_grid();
    do_cap(16'hFFFF);
    wait_idle();

    // Full mask, stalled ready pattern.
    ready_mode = 1;
    do_cap(16'hFFFF);
    wait_idle();

    // Diagonal with negative values.
    ready_mode = 0;
    for (int i = 0; i < E; i++) cv[i] = 7777;
    for (int r = 0; r < N; r++) cv[r*N+r] = -5 * (r + 1);
    do_cap(16'h8421);
    wait_idle();

    // Capture during drain with changed data.
    load_grid();
    do_cap(16'hFFFF);
    wait_left(14);
    for (int i = 0; i < E; i++) cv[i] = -i - 1000;
    do_cap(16'hFFFF);
    wait_idle();

    // Empty mask.
    do_cap(16'h0000);
    repeat (3) tick();

    // Reset mid-drain, then a fresh drain.
    load_grid();
    do_cap(16'hFFFF);
    wait_left(12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_busy", busy, 0);
    do_cap(16'hFFFF);
    wait_idle();

    // Randomised captures, masks and ready.
    ready_mode = 2;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < E; i++) cv[i] = int'($urandom);
      if ($urandom_range(0, 7) == 0) do_cap('0);
      else do_cap(E'($urandom));
      repeat ($urandom_range(0, 12)) tick();
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < E; i++) cv[i] = int'($urandom);
        do_cap(E'($urandom));
      end
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
